// File: rtl/float_triple_packer.sv
// Packs a valid/ready stream of FP64 words into triples, buffers two, and issues them to the sorter.
// Optional macro FLOAT_TRIPLE_PACKER_FLUSH_EN: flush pads a partial triple with +Inf.
module float_triple_packer #(
    parameter int SORT_LATENCY = 3,
    localparam int FLEN = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLEN-1:0]      in_data,
    input  logic                 flush,
    output logic                 sort_valid,
    output logic [0:2][FLEN-1:0] sort_unsorted,
    input  logic                 sort_busy,
    output logic [1:0]           level,
    output logic [1:0]           fill
);

    localparam int CW = (SORT_LATENCY > 1) ? $clog2(SORT_LATENCY) : 1;
    localparam logic [FLEN-1:0] POS_INF = {1'b0, 11'h7FF, 52'h0};

`ifdef FLOAT_TRIPLE_PACKER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    logic [FLEN-1:0]      slot [2][3];
    logic                 wr_ptr_reg;
    logic                 rd_ptr_reg;
    logic [1:0]           level_reg;
    logic [1:0]           fill_reg;
    logic [CW-1:0]        wait_cnt_reg;
    state_t               state_reg;

    logic                 accept;
    logic                 last_word;
    logic                 flush_go;
    logic                 complete;
    logic                 pop;
    logic [2:0]           word_we;
    logic [2:0][FLEN-1:0] word_wdata;

    assign in_ready  = (level_reg != 2'd2);
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (fill_reg == 2'd2);
    // Flush never completes a triple while both slots are full: there is nowhere to put it.
    assign flush_go  = FLUSH_EN && flush && in_ready && (fill_reg != 2'd0) && !last_word;
    assign complete  = last_word || flush_go;
    assign pop       = (state_reg == IDLE) && (level_reg != 2'd0) && !sort_busy;

    assign level = level_reg;
    assign fill  = fill_reg;

    // The accepted word takes its own position; padding covers every position after it.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_word
            localparam logic [1:0] IDX = 2'(gi);
            logic own;
            logic pad;
            assign own             = accept && (fill_reg == IDX);
            assign pad             = flush_go && ((IDX > fill_reg) || (!accept && (IDX == fill_reg)));
            assign word_we[gi]     = own || pad;
            assign word_wdata[gi]  = own ? in_data : POS_INF;
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (word_we[k]) begin
                slot[wr_ptr_reg][k] <= word_wdata[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            level_reg     <= 2'd0;
            fill_reg      <= 2'd0;
            wait_cnt_reg  <= '0;
            state_reg     <= IDLE;
            sort_valid    <= 1'b0;
            sort_unsorted <= '0;
        end else begin
            if (complete) begin
                fill_reg   <= 2'd0;
                wr_ptr_reg <= ~wr_ptr_reg;
            end else if (accept) begin
                fill_reg <= fill_reg + 2'd1;
            end

            case ({complete, pop})
                2'b10:   level_reg <= level_reg + 2'd1;
                2'b01:   level_reg <= level_reg - 2'd1;
                default: level_reg <= level_reg;
            endcase

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg     <= ISSUE;
                        sort_valid    <= 1'b1;
                        sort_unsorted <= {slot[rd_ptr_reg][0], slot[rd_ptr_reg][1], slot[rd_ptr_reg][2]};
                        rd_ptr_reg    <= ~rd_ptr_reg;
                    end
                end
                ISSUE: begin
                    sort_valid   <= 1'b0;
                    state_reg    <= WAIT;
                    wait_cnt_reg <= CW'(SORT_LATENCY - 1);
                end
                WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        if (!sort_busy) begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    sort_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_triple_packer.sv
// Scoreboard bench for float_triple_packer: directed scenarios plus randomized traffic against a queue model.
module tb_float_triple_packer;

    localparam int L   = 3;
    localparam int GAP = L + 2;
    localparam logic [63:0] F_1   = 64'h3FF0000000000000;
    localparam logic [63:0] F_3   = 64'h4008000000000000;
    localparam logic [63:0] F_2   = 64'h4000000000000000;
    localparam logic [63:0] F_5   = 64'h4014000000000000;
    localparam logic [63:0] F_M1  = 64'hBFF0000000000000;
    localparam logic [63:0] F_INF = 64'h7FF0000000000000;

`ifdef FLOAT_TRIPLE_PACKER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [63:0]       in_data = '0;
    logic              flush = 1'b0;
    logic              sort_valid;
    logic [0:2][63:0]  sort_unsorted;
    logic              sort_busy = 1'b0;
    logic [1:0]        level;
    logic [1:0]        fill;

    typedef struct {
        logic [0:2][63:0] t;
        int               cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] part_q[$];
    int          issue_edges[$];
    int          completes = 0;
    int          pops = 0;
    int          cyc = 0;
    int          last_issue = -1000;
    int          errors = 0;
    int          checks = 0;

    float_triple_packer #(.SORT_LATENCY(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .sort_valid   (sort_valid),
        .sort_unsorted(sort_unsorted),
        .sort_busy    (sort_busy),
        .level        (level),
        .fill         (fill)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk_int(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void chk_tri(string name, logic [0:2][63:0] act, logic [0:2][63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Model: words gather in part_q; every full (or flushed) group becomes an expected triple.
    initial begin : monitor
        int   mlevel;
        bit   acc;
        bit   fl;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                part_q.delete();
                completes  = 0;
                pops       = 0;
                last_issue = -1000;
            end else begin
                if (sort_valid) begin
                    issue_edges.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk_int("issue_without_triple", int'(sort_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk_tri("triple", sort_unsorted, e.t);
                        chk_int("issue_after_complete", int'(cyc > e.cyc), 1);
                    end
                    chk_int("issue_spacing", int'(cyc - last_issue >= GAP), 1);
                    last_issue = cyc;
                    pops++;
                end
                mlevel = completes - pops;
                chk_int("level", int'(level), mlevel);
                chk_int("fill", int'(fill), part_q.size());
                chk_int("in_ready", int'(in_ready), int'(mlevel != 2));
                acc = in_valid && (mlevel != 2);
                fl  = FLUSH_EN && flush && (mlevel != 2) && (part_q.size() != 0);
                if (acc) part_q.push_back(in_data);
                if (fl) begin
                    while (part_q.size() < 3) part_q.push_back(F_INF);
                end
                if (part_q.size() == 3) begin
                    e.t   = {part_q[0], part_q[1], part_q[2]};
                    e.cyc = cyc + 1;
                    exp_q.push_back(e);
                    part_q.delete();
                    completes++;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk_int("send_timeout", int'(in_ready), 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issues(input int target, input int budget);
        for (int i = 0; i < budget && issue_edges.size() < target; i++) cycles(1);
        chk_int("issue_count", issue_edges.size(), target);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t3;
        logic [63:0] a, b, c;

        cycles(2);
        chk_int("rst_sort_valid", int'(sort_valid), 0);
        chk_tri("rst_sort_unsorted", sort_unsorted, '0);
        chk_int("rst_level", int'(level), 0);
        chk_int("rst_fill", int'(fill), 0);
        chk_int("rst_in_ready", int'(in_ready), 1);
        rst = 1'b1;
        cycles(2);

        // Basic issue
        issue_edges.delete();
        send(F_1); send(F_3); send(F_2);
        t3 = cyc;
        in_valid = 1'b0;
        wait_issues(1, 20);
        if (issue_edges.size() > 0) chk_int("basic_latency", issue_edges[0], t3 + 1);
        chk_tri("basic_data", sort_unsorted, {F_1, F_3, F_2});
        cycles(2);
        chk_int("basic_level", int'(level), 0);

        // Back-to-back buffering with the sorter held busy
        cycles(8);
        issue_edges.delete();
        sort_busy = 1'b1;
        fork
            begin
                for (int i = 0; i < 9; i++) send({$urandom, $urandom});
            end
            begin
                cycles(10);
                chk_int("bb_in_ready", int'(in_ready), 0);
                chk_int("bb_level", int'(level), 2);
                chk_int("bb_fill", int'(fill), 0);
                sort_busy = 1'b0;
            end
        join
        in_valid = 1'b0;
        wait_issues(3, 100);
        if (issue_edges.size() >= 3) begin
            chk_int("bb_gap1", issue_edges[1] - issue_edges[0], GAP);
            chk_int("bb_gap2", issue_edges[2] - issue_edges[1], GAP);
        end

        // Triple B completes on the same edge that triple A pops
        cycles(8);
        sort_busy = 1'b1;
        for (int i = 0; i < 5; i++) send({$urandom, $urandom});
        in_valid = 1'b0;
        cycles(2);
        issue_edges.delete();
        sort_busy = 1'b0;
        in_valid  = 1'b1;
        in_data   = {$urandom, $urandom};
        @(negedge clk);
        chk_int("simul_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk_int("simul_level", int'(level), 1);
        chk_int("simul_pop", int'(sort_valid), 1);
        cycles(1);
        wait_issues(2, 30);

        // Flush of a two-word partial triple
        cycles(8);
        issue_edges.delete();
        send(F_5); send(F_M1);
        in_valid = 1'b0;
        flush = 1'b1;
        cycles(1);
        flush = 1'b0;
        if (FLUSH_EN) begin
            chk_int("flush_fill", int'(fill), 0);
            wait_issues(1, 20);
            chk_tri("flush_data", sort_unsorted, {F_5, F_M1, F_INF});
        end else begin
            cycles(10);
            chk_int("noflush_fill", int'(fill), 2);
            chk_int("noflush_issues", issue_edges.size(), 0);
            send(F_2);
            in_valid = 1'b0;
            wait_issues(1, 20);
            chk_tri("noflush_data", sort_unsorted, {F_5, F_M1, F_2});
        end

        // Flush together with the third word adds no padding
        cycles(8);
        issue_edges.delete();
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
        send(a); send(b);
        flush = 1'b1;
        send(c);
        flush = 1'b0;
        in_valid = 1'b0;
        chk_int("flush3_fill", int'(fill), 0);
        wait_issues(1, 20);
        chk_tri("flush3_data", sort_unsorted, {a, b, c});

        // Reset while waiting with one triple buffered
        cycles(8);
        issue_edges.delete();
        for (int i = 0; i < 6; i++) send({$urandom, $urandom});
        in_valid = 1'b0;
        @(negedge clk);
        chk_int("rstw_pre_level", int'(level), 1);
        #1 rst = 1'b0;
        #1;
        chk_int("rstw_sort_valid", int'(sort_valid), 0);
        chk_tri("rstw_sort_unsorted", sort_unsorted, '0);
        chk_int("rstw_level", int'(level), 0);
        chk_int("rstw_fill", int'(fill), 0);
        chk_int("rstw_in_ready", int'(in_ready), 1);
        cycles(2);
        rst = 1'b1;
        issue_edges.delete();
        cycles(10);
        chk_int("rstw_no_issue", issue_edges.size(), 0);
        for (int i = 0; i < 3; i++) send({$urandom, $urandom});
        in_valid = 1'b0;
        wait_issues(1, 20);

        // Reset during the issue pulse drops sort_valid at once
        cycles(8);
        for (int i = 0; i < 3; i++) send({$urandom, $urandom});
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sort_valid) break;
        end
        chk_int("rsti_pre_valid", int'(sort_valid), 1);
        #1 rst = 1'b0;
        #1;
        chk_int("rsti_sort_valid", int'(sort_valid), 0);
        cycles(2);
        rst = 1'b1;
        cycles(2);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = {$urandom, $urandom};
            sort_busy = ($urandom_range(0, 9) < 3);
            flush     = ($urandom_range(0, 9) == 0);
            cycles(1);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        sort_busy = 1'b0;
        cycles(60);
        chk_int("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
